inst_fetch: RTL and testbench

Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of the decode stage. Reads each 32-bit instruction as four little-endian bytes over the shared 8-bit memory arbiter port and presents {pc, inst} to decode through a single-entry output register. The output register holds its contents while decode stalls. On a branch redirect, it flushes both the output register and the in-progress fetch.

---
 rtl/inst_fetch.sv | 181 ++++++++++++++++++
 tb/tb_inst_fetch.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// RV32I instruction fetch: assembles each word from four byte reads on the shared arbiter port.
// Optional direct-mapped I-cache enabled by defining ICACHE_EN.
module inst_fetch #(
  parameter int unsigned ICACHE_LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        if_req_o,
  output logic [31:0] if_addr_o,
  input  logic        if_gnt_i,
  input  logic [7:0]  mem_byte_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  typedef enum logic [1:0] {StReq, StLast, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  lane_q, lane_d;
  logic        pend_q, pend_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;

  logic        slot_free;
  logic        load;
  logic [31:0] load_word;
  logic        cache_hit;
  logic [31:0] cache_word;

  assign slot_free    = !valid_q || !stall_i;
  assign if_addr_o    = fetch_pc_q + {30'd0, cnt_q};
  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    cnt_d      = cnt_q;
    lane_d     = lane_q;
    pend_d     = 1'b0;
    asm_d      = asm_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    valid_d    = valid_q && stall_i;
    if_req_o   = 1'b0;
    load       = 1'b0;
    load_word  = asm_q;

    // A granted byte lands in the lane recorded at its grant.
    if (pend_q) begin
      asm_d[{lane_q, 3'b000} +: 8] = mem_byte_i;
    end

    case (state_q)
      StReq: begin
        if (cache_hit) begin
          if (slot_free) begin
            load      = 1'b1;
            load_word = cache_word;
          end
        end else begin
          if_req_o = 1'b1;
          if (if_gnt_i) begin
            pend_d = 1'b1;
            lane_d = cnt_q;
            cnt_d  = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              state_d = StLast;
            end
          end
        end
      end
      StLast: begin
        if (slot_free) begin
          load      = 1'b1;
          load_word = {mem_byte_i, asm_q[23:0]};
        end else begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (slot_free) begin
          load = 1'b1;
        end
      end
      default: state_d = StReq;
    endcase

    if (load) begin
      pc_d       = fetch_pc_q;
      inst_d     = load_word;
      valid_d    = 1'b1;
      fetch_pc_d = fetch_pc_q + 32'd4;
      cnt_d      = 2'd0;
      state_d    = StReq;
    end

    // Redirect overrides any load or grant made in the same cycle.
    if (branch_taken_i) begin
      fetch_pc_d = branch_target_i;
      cnt_d      = 2'd0;
      pend_d     = 1'b0;
      valid_d    = 1'b0;
      state_d    = StReq;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StReq;
      fetch_pc_q <= 32'd0;
      cnt_q      <= 2'd0;
      lane_q     <= 2'd0;
      pend_q     <= 1'b0;
      asm_q      <= 32'd0;
      pc_q       <= 32'd0;
      inst_q     <= 32'd0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      cnt_q      <= cnt_d;
      lane_q     <= lane_d;
      pend_q     <= pend_d;
      asm_q      <= asm_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
    end
  end

`ifdef ICACHE_EN
  localparam int unsigned IdxW = $clog2(ICACHE_LINES);
  localparam int unsigned TagW = 30 - IdxW;

  logic [ICACHE_LINES-1:0] cvalid_q;
  logic [TagW-1:0]         ctag_q  [ICACHE_LINES];
  logic [31:0]             cdata_q [ICACHE_LINES];
  logic [IdxW-1:0]         cidx;
  logic [TagW-1:0]         ctag;
  logic                    cwr;

  assign cidx       = fetch_pc_q[2 +: IdxW];
  assign ctag       = fetch_pc_q[31:2+IdxW];
  assign cache_word = cdata_q[cidx];
  // Only look up at a word boundary with nothing in flight.
  assign cache_hit  = (state_q == StReq) && (cnt_q == 2'd0) && !pend_q &&
                      cvalid_q[cidx] && (ctag_q[cidx] == ctag);
  assign cwr        = load && !branch_taken_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      cvalid_q <= '0;
    end else if (cwr) begin
      cvalid_q[cidx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cwr) begin
      ctag_q[cidx]  <= ctag;
      cdata_q[cidx] <= load_word;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^ICACHE_LINES;
  assign cache_hit  = 1'b0;
  assign cache_word = 32'd0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: byte-level memory/arbiter environment plus a
// word-stream reference model (expected PC sequence and memory contents).
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = 32'd0;
  logic        if_req_o;
  logic [31:0] if_addr_o;
  logic        if_gnt_i = 1'b1;
  logic [7:0]  mem_byte_i = 8'd0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: PC of the next word to be presented, and grants seen for it.
  logic [31:0] m_next = 32'd0;
  int          gcnt = 0;

  inst_fetch #(.ICACHE_LINES(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .if_req_o        (if_req_o),
    .if_addr_o       (if_addr_o),
    .if_gnt_i        (if_gnt_i),
    .mem_byte_i      (mem_byte_i),
    .pc_o            (pc_o),
    .inst_o          (inst_o),
    .inst_valid_o    (inst_valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem32(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h0010_0113;
      32'h0000_0008: return 32'h0020_81B3;
      32'h0000_000C: return 32'h0031_8233;
      32'h0000_0010: return 32'hFFC1_0113;
      32'h0000_0100: return 32'h1234_5678;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endcase
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w;
    w = mem32({a[31:2], 2'b00});
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  // One clock cycle: arbiter/memory response plus reference-model checks.
  task automatic step();
    logic        g, was_valid, was_stall, was_br, was_rst;
    logic [31:0] ga, tgt, old_pc, old_inst;
    #1;
    g         = (if_req_o === 1'b1) && (if_gnt_i === 1'b1);
    ga        = if_addr_o;
    was_valid = inst_valid_o;
    was_stall = stall_i;
    was_br    = branch_taken_i;
    was_rst   = rst;
    tgt       = branch_target_i;
    old_pc    = pc_o;
    old_inst  = inst_o;
    if (!was_rst && !was_br && g) begin
      vectors++;
      if (ga !== m_next + 32'(gcnt)) begin
        miscompares++;
        $display("FAIL grant_addr: got %h want %h", ga, m_next + 32'(gcnt));
      end
      gcnt++;
    end
    @(posedge clk);
    #1;
    mem_byte_i = g ? mem_byte(ga) : 8'($urandom);
    if (was_rst) begin
      m_next = 32'd0;
      gcnt   = 0;
      vectors++;
      if (inst_valid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_valid: got %b want 0", inst_valid_o);
      end
    end else if (was_br) begin
      m_next = tgt;
      gcnt   = 0;
      vectors++;
      if (inst_valid_o !== 1'b0 || if_addr_o !== tgt) begin
        miscompares++;
        $display("FAIL redirect: valid %b addr %h want valid 0 addr %h",
                 inst_valid_o, if_addr_o, tgt);
      end
    end else if (inst_valid_o === 1'b1 && (!was_valid || !was_stall)) begin
      vectors++;
      if (pc_o !== m_next || inst_o !== mem32(m_next)) begin
        miscompares++;
        $display("FAIL present: pc %h inst %h want pc %h inst %h",
                 pc_o, inst_o, m_next, mem32(m_next));
      end
`ifndef ICACHE_EN
      vectors++;
      if (gcnt != 4) begin
        miscompares++;
        $display("FAIL byte_count: got %0d grants want 4", gcnt);
      end
`endif
      m_next = m_next + 32'd4;
      gcnt   = 0;
    end else if (was_valid && was_stall) begin
      vectors++;
      if (inst_valid_o !== 1'b1 || pc_o !== old_pc || inst_o !== old_inst) begin
        miscompares++;
        $display("FAIL stall_hold: valid %b pc %h inst %h want 1 %h %h",
                 inst_valid_o, pc_o, inst_o, old_pc, old_inst);
      end
    end else begin
      vectors++;
      if (inst_valid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_valid: got %b want 0", inst_valid_o);
      end
    end
  endtask

  task automatic redirect(input logic [31:0] t);
    branch_taken_i  = 1'b1;
    branch_target_i = t;
    step();
    branch_taken_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_i = 1'b0; branch_taken_i = 1'b0; if_gnt_i = 1'b1;
    step();
    step();
    vectors++;
    if (pc_o !== 32'd0 || inst_o !== 32'd0 || inst_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: pc %h inst %h valid %b want 0 0 0", pc_o, inst_o, inst_valid_o);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (if_req_o !== 1'b1 || if_addr_o !== 32'(i)) begin
        miscompares++;
        $display("FAIL reset_req%0d: req %b addr %h want 1 %h", i, if_req_o, if_addr_o, 32'(i));
      end
      step();
    end
    vectors++;
    if (if_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_last: req %b valid %b want 0 0", if_req_o, inst_valid_o);
    end
    step();
    vectors++;
    if (inst_valid_o !== 1'b1 || pc_o !== 32'd0 || inst_o !== 32'h0050_0093) begin
      miscompares++;
      $display("FAIL reset_first: valid %b pc %h inst %h want 1 0 00500093",
               inst_valid_o, pc_o, inst_o);
    end
    vectors++;
    if (if_req_o !== 1'b1 || if_addr_o !== 32'd4) begin
      miscompares++;
      $display("FAIL reset_next: req %b addr %h want 1 4", if_req_o, if_addr_o);
    end
  endtask

  task automatic test_stall();
    int n = 0;
    while (!(inst_valid_o === 1'b1 && pc_o === 32'd4) && n < 20) begin
      step();
      n++;
    end
    vectors++;
    if (n >= 20) begin
      miscompares++;
      $display("FAIL stall_wait: got timeout want pc 4 valid");
    end
    stall_i = 1'b1;
    for (int i = 0; i < 12; i++) step();
    vectors++;
    if (if_req_o !== 1'b0 || pc_o !== 32'd4 || inst_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_quiet: req %b pc %h valid %b want 0 4 1", if_req_o, pc_o, inst_valid_o);
    end
    stall_i = 1'b0;
    step();
    vectors++;
    if (inst_valid_o !== 1'b1 || pc_o !== 32'd8 || inst_o !== mem32(32'd8)) begin
      miscompares++;
      $display("FAIL stall_release: valid %b pc %h want 1 8", inst_valid_o, pc_o);
    end
  endtask

  task automatic test_grant_gaps();
    int lat = 0;
    redirect(32'h10);
    for (int i = 0; i < 16; i++) begin
      if_gnt_i = i[0];
      step();
      if (inst_valid_o === 1'b1) begin
        lat = i + 1;
        break;
      end
    end
    if_gnt_i = 1'b1;
    vectors++;
    if (lat != 9 || pc_o !== 32'h10 || inst_o !== 32'hFFC1_0113) begin
      miscompares++;
      $display("FAIL gaps: latency %0d pc %h inst %h want 9 10 ffc10113", lat, pc_o, inst_o);
    end
  endtask

  task automatic test_redirect_mid();
    int lat = 0;
    redirect(32'h8);
    step();
    step();
    step();
    redirect(32'h100);
    vectors++;
    if (inst_valid_o !== 1'b0 || if_addr_o !== 32'h100) begin
      miscompares++;
      $display("FAIL mid_redirect: valid %b addr %h want 0 100", inst_valid_o, if_addr_o);
    end
    while (inst_valid_o !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    vectors++;
    if (lat != 5 || pc_o !== 32'h100 || inst_o !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL mid_target: latency %0d pc %h inst %h want 5 100 12345678",
               lat, pc_o, inst_o);
    end
  endtask

  task automatic test_redirect_stall();
    int n = 0;
    stall_i = 1'b1;
    redirect(32'h40);
    vectors++;
    if (inst_valid_o !== 1'b0 || if_addr_o !== 32'h40) begin
      miscompares++;
      $display("FAIL br_stall: valid %b addr %h want 0 40", inst_valid_o, if_addr_o);
    end
    while (inst_valid_o !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    vectors++;
    if (pc_o !== 32'h40 || inst_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL br_stall_target: pc %h valid %b want 40 1", pc_o, inst_valid_o);
    end
    stall_i = 1'b0;
  endtask

  task automatic test_wrap();
    int n = 0;
    redirect(32'hFFFF_FFF8);
    while (!(inst_valid_o === 1'b1 && pc_o === 32'd0) && n < 40) begin
      step();
      n++;
    end
    vectors++;
    if (n >= 40) begin
      miscompares++;
      $display("FAIL wrap: got timeout want pc 0 after fffffffc");
    end
  endtask

`ifdef ICACHE_EN
  task automatic test_cache();
    int n = 0;
    redirect(32'h20);
    while (!(inst_valid_o === 1'b1 && pc_o === 32'h2C) && n < 60) begin
      step();
      n++;
    end
    redirect(32'h20);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (if_req_o !== 1'b0) begin
        miscompares++;
        $display("FAIL cache_req%0d: got %b want 0", k, if_req_o);
      end
      step();
      vectors++;
      if (inst_valid_o !== 1'b1 || pc_o !== 32'h20 + 32'(4 * k)) begin
        miscompares++;
        $display("FAIL cache_hit%0d: valid %b pc %h want 1 %h", k, inst_valid_o, pc_o,
                 32'h20 + 32'(4 * k));
      end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    redirect(32'h20);
    vectors++;
    if (if_req_o !== 1'b1 || if_addr_o !== 32'h20) begin
      miscompares++;
      $display("FAIL cache_reset: req %b addr %h want 1 20", if_req_o, if_addr_o);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if_gnt_i        = ($urandom % 4) != 0;
      stall_i         = ($urandom % 3) == 0;
      branch_taken_i  = ($urandom % 50) == 0;
      branch_target_i = 32'($urandom_range(0, 127)) << 2;
      step();
    end
    branch_taken_i = 1'b0;
    stall_i        = 1'b0;
    if_gnt_i       = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stall();
    test_grant_gaps();
    test_redirect_mid();
    test_redirect_stall();
    test_wrap();
`ifdef ICACHE_EN
    test_cache();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
